fir_coef_loader: RTL

- Upstream configuration stage for the 16-tap FIR.
- Accepts a serial stream of 16 signed 12-bit coefficients over a valid/ready handshake into a shadow bank.
- Commits the bank atomically to the 16 parallel coefficient outputs that feed the FIR coef0..coef15 inputs, and drives the FIR control (enable) input.
- The FIR keeps filtering with the old bank while a new one loads; the swap is glitch-free.

---
 rtl/fir_coef_loader_pkg.sv | 14 +
 rtl/fir_coef_loader_if.sv | 32 +++
 rtl/fir_coef_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/fir_coef_loader_pkg.sv
// Shared constants and types for the FIR coefficient loader.
package fir_coef_loader_pkg;

    localparam int COEF_W = 12;
    localparam int N_TAPS = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coef_loader_if.sv
// Coefficient stream and load-status signals between the configuration source and the loader.
interface fir_coef_loader_if;
    import fir_coef_loader_pkg::*;

    // A word moves on a rising clk edge where coef_valid && coef_ready are both high;
    // coef_ready never depends on coef_valid, and a held-off word must stay stable.
    logic              load_start;
    logic [COEF_W-1:0] coef_in;
    logic              coef_valid;
    logic              coef_ready;
    logic              load_done;
    logic              busy;

    modport master (
        output load_start,
        output coef_in,
        output coef_valid,
        input  coef_ready,
        input  load_done,
        input  busy
    );

    modport slave (
        input  load_start,
        input  coef_in,
        input  coef_valid,
        output coef_ready,
        output load_done,
        output busy
    );

endinterface

// File: rtl/fir_coef_loader.sv
// Loads 16 serial coefficients into a shadow bank and swaps them into the active bank in one edge.
module fir_coef_loader
    import fir_coef_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fir_coef_loader_if.slave  cfg,
    output logic [COEF_W-1:0] coef0,
    output logic [COEF_W-1:0] coef1,
    output logic [COEF_W-1:0] coef2,
    output logic [COEF_W-1:0] coef3,
    output logic [COEF_W-1:0] coef4,
    output logic [COEF_W-1:0] coef5,
    output logic [COEF_W-1:0] coef6,
    output logic [COEF_W-1:0] coef7,
    output logic [COEF_W-1:0] coef8,
    output logic [COEF_W-1:0] coef9,
    output logic [COEF_W-1:0] coef10,
    output logic [COEF_W-1:0] coef11,
    output logic [COEF_W-1:0] coef12,
    output logic [COEF_W-1:0] coef13,
    output logic [COEF_W-1:0] coef14,
    output logic [COEF_W-1:0] coef15,
    output logic              control,
    output logic [1:0]        state_dbg
);

    state_t            state;
    logic [IDX_W-1:0]  index;
    logic              commit_q;
    logic              load_done_q;
    logic [COEF_W-1:0] shadow [N_TAPS];
    logic [COEF_W-1:0] active [N_TAPS];

    // The COMMIT edge raises commit_q; the bank copy and load_done then land on the next edge together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            index       <= '0;
            commit_q    <= 1'b0;
            load_done_q <= 1'b0;
            control     <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            commit_q    <= 1'b0;
            load_done_q <= commit_q;
            if (commit_q) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    active[i] <= shadow[i];
                end
                control <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cfg.load_start) begin
                        state <= ST_LOAD;
                        index <= '0;
                    end
                end
                ST_LOAD: begin
                    // A restart wins over a coincident word, which is dropped.
                    if (cfg.load_start) begin
                        index <= '0;
                    end else if (cfg.coef_valid) begin
                        shadow[index] <= cfg.coef_in;
                        index         <= index + 4'd1;
                        if (index == 4'(N_TAPS - 1)) begin
                            state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    commit_q <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    index <= '0;
                end
            endcase
        end
    end

    assign cfg.coef_ready = (state == ST_LOAD);
    assign cfg.busy       = (state != ST_IDLE);
    assign cfg.load_done  = load_done_q;
    assign state_dbg      = state;

    assign coef0  = active[0];
    assign coef1  = active[1];
    assign coef2  = active[2];
    assign coef3  = active[3];
    assign coef4  = active[4];
    assign coef5  = active[5];
    assign coef6  = active[6];
    assign coef7  = active[7];
    assign coef8  = active[8];
    assign coef9  = active[9];
    assign coef10 = active[10];
    assign coef11 = active[11];
    assign coef12 = active[12];
    assign coef13 = active[13];
    assign coef14 = active[14];
    assign coef15 = active[15];

endmodule
